// File: rtl/axi2to1_arbiter.sv
// axi2to1_arbiter: merges two AXI4 requesters (s0, s1) onto one AXI4 master port.
//   clock, reset     : single clock, synchronous active-high reset
//   s0_axi_* / s1_*  : slave ports, ID width SID_W
//   m_axi_*          : master port, ID width SID_W+1, id = {requester index, slave id}
// Reads and writes arbitrate independently with their own round-robin pointers.
// Read and write responses are steered back by the top ID bit without any state,
// so any number of reads and write responses may be outstanding.
module axi2to1_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 36,
  parameter int unsigned SID_W  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  // requester 0
  input  logic [SID_W-1:0]      s0_axi_awid,
  input  logic [ADDR_W-1:0]     s0_axi_awaddr,
  input  logic [7:0]            s0_axi_awlen,
  input  logic [2:0]            s0_axi_awsize,
  input  logic [1:0]            s0_axi_awburst,
  input  logic                  s0_axi_awlock,
  input  logic [3:0]            s0_axi_awcache,
  input  logic [2:0]            s0_axi_awprot,
  input  logic [3:0]            s0_axi_awqos,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_W-1:0]     s0_axi_wdata,
  input  logic [DATA_W/8-1:0]   s0_axi_wstrb,
  input  logic                  s0_axi_wlast,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [SID_W-1:0]      s0_axi_bid,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [SID_W-1:0]      s0_axi_arid,
  input  logic [ADDR_W-1:0]     s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arlock,
  input  logic [3:0]            s0_axi_arcache,
  input  logic [2:0]            s0_axi_arprot,
  input  logic [3:0]            s0_axi_arqos,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [SID_W-1:0]      s0_axi_rid,
  output logic [DATA_W-1:0]     s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // requester 1
  input  logic [SID_W-1:0]      s1_axi_awid,
  input  logic [ADDR_W-1:0]     s1_axi_awaddr,
  input  logic [7:0]            s1_axi_awlen,
  input  logic [2:0]            s1_axi_awsize,
  input  logic [1:0]            s1_axi_awburst,
  input  logic                  s1_axi_awlock,
  input  logic [3:0]            s1_axi_awcache,
  input  logic [2:0]            s1_axi_awprot,
  input  logic [3:0]            s1_axi_awqos,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_W-1:0]     s1_axi_wdata,
  input  logic [DATA_W/8-1:0]   s1_axi_wstrb,
  input  logic                  s1_axi_wlast,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [SID_W-1:0]      s1_axi_bid,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [SID_W-1:0]      s1_axi_arid,
  input  logic [ADDR_W-1:0]     s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arlock,
  input  logic [3:0]            s1_axi_arcache,
  input  logic [2:0]            s1_axi_arprot,
  input  logic [3:0]            s1_axi_arqos,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [SID_W-1:0]      s1_axi_rid,
  output logic [DATA_W-1:0]     s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // shared master
  output logic [SID_W:0]        m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [SID_W:0]        m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [SID_W:0]        m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [SID_W:0]        m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic {RD_IDLE, RD_ADDR} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA} wr_state_t;

  rd_state_t rd_state, rd_state_nxt;
  logic      rd_grant, rd_grant_nxt;   // 0 = s0, 1 = s1
  logic      rd_last,  rd_last_nxt;    // requester of the last completed AR
  wr_state_t wr_state, wr_state_nxt;
  logic      wr_grant, wr_grant_nxt;
  logic      wr_last,  wr_last_nxt;    // requester of the last completed write burst

  logic rd_addr_act;
  logic wr_addr_act;
  logic wr_data_act;
  logic ar_hs;
  logic w_last_hs;

  // Valid/ready qualifiers are masked by reset so nothing leaks out while it is held.
  assign rd_addr_act = (rd_state == RD_ADDR) && !reset;
  assign wr_addr_act = (wr_state == WR_ADDR) && !reset;
  assign wr_data_act = (wr_state == WR_DATA) && !reset;
  assign ar_hs       = m_axi_arvalid && m_axi_arready;
  assign w_last_hs   = m_axi_wvalid && m_axi_wready && m_axi_wlast;

  // Read arbiter state register
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_grant <= 1'b0;
      rd_last  <= 1'b1;
    end else begin
      rd_state <= rd_state_nxt;
      rd_grant <= rd_grant_nxt;
      rd_last  <= rd_last_nxt;
    end
  end

  // Read arbiter next state: on a tie the requester not served last wins
  always_comb begin
    rd_state_nxt = rd_state;
    rd_grant_nxt = rd_grant;
    rd_last_nxt  = rd_last;
    case (rd_state)
      RD_IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          rd_grant_nxt = (s0_axi_arvalid && s1_axi_arvalid) ? !rd_last : s1_axi_arvalid;
          rd_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          rd_last_nxt  = rd_grant;
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Write arbiter state register
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_grant <= 1'b0;
      wr_last  <= 1'b1;
    end else begin
      wr_state <= wr_state_nxt;
      wr_grant <= wr_grant_nxt;
      wr_last  <= wr_last_nxt;
    end
  end

  // Write arbiter next state: one burst at a time, pointer moves on wlast
  always_comb begin
    wr_state_nxt = wr_state;
    wr_grant_nxt = wr_grant;
    wr_last_nxt  = wr_last;
    case (wr_state)
      WR_IDLE: begin
        if (s0_axi_awvalid || s1_axi_awvalid) begin
          wr_grant_nxt = (s0_axi_awvalid && s1_axi_awvalid) ? !wr_last : s1_axi_awvalid;
          wr_state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (m_axi_awvalid && m_axi_awready) wr_state_nxt = WR_DATA;
      end
      WR_DATA: begin
        if (w_last_hs) begin
          wr_last_nxt  = wr_grant;
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // AR mux toward the master
  assign m_axi_arvalid  = rd_addr_act;
  assign m_axi_arid     = {rd_grant, rd_grant ? s1_axi_arid : s0_axi_arid};
  assign m_axi_araddr   = rd_grant ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen    = rd_grant ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize   = rd_grant ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst  = rd_grant ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock   = rd_grant ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache  = rd_grant ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot   = rd_grant ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arqos    = rd_grant ? s1_axi_arqos   : s0_axi_arqos;
  assign s0_axi_arready = rd_addr_act && !rd_grant && m_axi_arready;
  assign s1_axi_arready = rd_addr_act &&  rd_grant && m_axi_arready;

  // AW mux toward the master
  assign m_axi_awvalid  = wr_addr_act;
  assign m_axi_awid     = {wr_grant, wr_grant ? s1_axi_awid : s0_axi_awid};
  assign m_axi_awaddr   = wr_grant ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen    = wr_grant ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize   = wr_grant ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst  = wr_grant ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock   = wr_grant ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache  = wr_grant ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot   = wr_grant ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awqos    = wr_grant ? s1_axi_awqos   : s0_axi_awqos;
  assign s0_axi_awready = wr_addr_act && !wr_grant && m_axi_awready;
  assign s1_axi_awready = wr_addr_act &&  wr_grant && m_axi_awready;

  // W path is only open during the data phase of the granted burst
  assign m_axi_wvalid   = wr_data_act && (wr_grant ? s1_axi_wvalid : s0_axi_wvalid);
  assign m_axi_wdata    = wr_grant ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb    = wr_grant ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast    = wr_grant ? s1_axi_wlast : s0_axi_wlast;
  assign s0_axi_wready  = wr_data_act && !wr_grant && m_axi_wready;
  assign s1_axi_wready  = wr_data_act &&  wr_grant && m_axi_wready;

  // R return: steered by the requester bit of rid, payload broadcast
  assign s0_axi_rvalid  = m_axi_rvalid && !m_axi_rid[SID_W];
  assign s1_axi_rvalid  = m_axi_rvalid &&  m_axi_rid[SID_W];
  assign s0_axi_rid     = m_axi_rid[SID_W-1:0];
  assign s1_axi_rid     = m_axi_rid[SID_W-1:0];
  assign s0_axi_rdata   = m_axi_rdata;
  assign s1_axi_rdata   = m_axi_rdata;
  assign s0_axi_rresp   = m_axi_rresp;
  assign s1_axi_rresp   = m_axi_rresp;
  assign s0_axi_rlast   = m_axi_rlast;
  assign s1_axi_rlast   = m_axi_rlast;
  assign m_axi_rready   = m_axi_rid[SID_W] ? s1_axi_rready : s0_axi_rready;

  // B return: same steering as R
  assign s0_axi_bvalid  = m_axi_bvalid && !m_axi_bid[SID_W];
  assign s1_axi_bvalid  = m_axi_bvalid &&  m_axi_bid[SID_W];
  assign s0_axi_bid     = m_axi_bid[SID_W-1:0];
  assign s1_axi_bid     = m_axi_bid[SID_W-1:0];
  assign s0_axi_bresp   = m_axi_bresp;
  assign s1_axi_bresp   = m_axi_bresp;
  assign m_axi_bready   = m_axi_bid[SID_W] ? s1_axi_bready : s0_axi_bready;

endmodule

// File: tb/tb_axi2to1_arbiter.sv
// Directed self-checking bench for axi2to1_arbiter (default parameters).
module tb_axi2to1_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 36;
  localparam int unsigned IW = 7;

  logic clock, reset;

  logic [IW-1:0] s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [7:0]    s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0]    s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
  logic [1:0]    s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic          s0_axi_awlock, s1_axi_awlock, s0_axi_arlock, s1_axi_arlock;
  logic [3:0]    s0_axi_awcache, s1_axi_awcache, s0_axi_arcache, s1_axi_arcache;
  logic [2:0]    s0_axi_awprot, s1_axi_awprot, s0_axi_arprot, s1_axi_arprot;
  logic [3:0]    s0_axi_awqos, s1_axi_awqos, s0_axi_arqos, s1_axi_arqos;
  logic          s0_axi_awvalid, s1_axi_awvalid, s0_axi_arvalid, s1_axi_arvalid;
  logic          s0_axi_awready, s1_axi_awready, s0_axi_arready, s1_axi_arready;
  logic [DW-1:0] s0_axi_wdata, s1_axi_wdata, s0_axi_rdata, s1_axi_rdata;
  logic [DW/8-1:0] s0_axi_wstrb, s1_axi_wstrb;
  logic          s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
  logic          s0_axi_wready, s1_axi_wready;
  logic [IW-1:0] s0_axi_bid, s1_axi_bid, s0_axi_rid, s1_axi_rid;
  logic [1:0]    s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
  logic          s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic          s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready;

  logic [IW:0]   m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi2to1_arbiter dut (
    .clock(clock), .reset(reset),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock),
    .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot), .s0_axi_awqos(s0_axi_awqos),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
    .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot), .s0_axi_arqos(s0_axi_arqos),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock),
    .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot), .s1_axi_awqos(s1_axi_awqos),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
    .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot), .s1_axi_arqos(s1_axi_arqos),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // response routing vectors: inputs, then expected outputs
  typedef struct {
    logic [7:0] rid; logic rv; logic rl; logic s0rr; logic s1rr;
    logic [7:0] bid; logic bv; logic s0br; logic s1br;
    logic e_s0rv; logic e_s1rv; logic [6:0] e_rid; logic e_rl; logic e_mrr;
    logic e_s0bv; logic e_s1bv; logic e_mbr;
  } vec_t;
  vec_t tbl[5];

  logic gr[3];
  int   g;
  int   nb;
  logic [IW-1:0] rid_seen;
  logic          rl_seen;

  initial begin
    tbl[0] = '{8'h83, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b1, 7'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'h83, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1,
               1'b0, 1'b1, 7'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h85, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b0, 7'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 8'h85, 1'b0, 1'b1, 1'b0,
               1'b1, 1'b0, 7'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7f, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst, s0_axi_awlock,
     s0_axi_awcache, s0_axi_awprot, s0_axi_awqos, s0_axi_awvalid} = '0;
    {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst, s1_axi_awlock,
     s1_axi_awcache, s1_axi_awprot, s1_axi_awqos, s1_axi_awvalid} = '0;
    {s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst, s0_axi_arlock,
     s0_axi_arcache, s0_axi_arprot, s0_axi_arqos} = '0;
    {s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst, s1_axi_arlock,
     s1_axi_arcache, s1_axi_arprot, s1_axi_arqos} = '0;
    {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast} = '0;
    {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast} = '0;
    {s0_axi_bready, s1_axi_bready, s0_axi_rready, s1_axi_rready} = '0;
    {m_axi_bid, m_axi_bresp, m_axi_bvalid} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid} = '0;
    // both readers request across reset release, id 5 each
    s0_axi_arid = 7'h05; s1_axi_arid = 7'h05;
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
    s0_axi_wvalid = 1'b1; s1_axi_wvalid = 1'b1;
    m_axi_arready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;

    step(); step();
    #1;
    chk("rst_m_arvalid", m_axi_arvalid, 0);
    chk("rst_m_awvalid", m_axi_awvalid, 0);
    chk("rst_m_wvalid", m_axi_wvalid, 0);
    chk("rst_s0_arready", s0_axi_arready, 0);
    chk("rst_s1_arready", s1_axi_arready, 0);
    chk("rst_s0_wready", s0_axi_wready, 0);
    chk("rst_s1_wready", s1_axi_wready, 0);
    chk("rst_s0_awready", s0_axi_awready, 0);
    s0_axi_wvalid = 1'b0; s1_axi_wvalid = 1'b0;
    m_axi_arready = 1'b0;
    reset = 1'b0;
    #1;
    chk("ar_latency", m_axi_arvalid, 0);

    // first tie after reset goes to s0, then s1
    step();
    chk("tie_arvalid", m_axi_arvalid, 1);
    chk("tie_arid_s0", m_axi_arid, 8'h05);
    chk("tie_s1_arready", s1_axi_arready, 0);
    step();
    chk("hold_arid", m_axi_arid, 8'h05);
    chk("hold_s1_arready", s1_axi_arready, 0);
    m_axi_arready = 1'b1;
    #1;
    chk("hs_s0_arready", s0_axi_arready, 1);
    chk("hs_s1_arready", s1_axi_arready, 0);
    step();
    s0_axi_arvalid = 1'b0;
    #1;
    chk("post_hs_arvalid", m_axi_arvalid, 0);
    step();
    chk("tie_arid_s1", m_axi_arid, 8'h85);
    chk("s1_arready", s1_axi_arready, 1);
    chk("s0_arready_off", s0_axi_arready, 0);
    step();
    s1_axi_arvalid = 1'b0;

    // s0 holds arvalid, s1 asks once: expect s0, s1, s0
    s0_axi_arid = 7'h01; s1_axi_arid = 7'h02;
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
    g = 0;
    for (int c = 0; c < 20 && g < 3; c++) begin
      #1;
      if (m_axi_arvalid && m_axi_arready) begin
        gr[g] = m_axi_arid[IW];
        g++;
      end
      step();
      if (g > 0 && gr[g-1]) s1_axi_arvalid = 1'b0;
    end
    chk("rr_count", 64'(g), 3);
    chk("rr_grant0", gr[0], 0);
    chk("rr_grant1", gr[1], 1);
    chk("rr_grant2", gr[2], 0);
    s0_axi_arvalid = 1'b0;
    step();

    // s1 write burst of 4 with s0 AW pending; a read runs alongside
    m_axi_awready = 1'b0; m_axi_wready = 1'b1;
    s1_axi_awvalid = 1'b1; s1_axi_awid = 7'h02; s1_axi_awlen = 8'd3; s1_axi_awaddr = 36'h1234;
    s1_axi_wvalid = 1'b1; s1_axi_wdata = 64'ha0; s1_axi_wlast = 1'b0;
    s0_axi_arvalid = 1'b1; s0_axi_arid = 7'h11;
    #1;
    chk("early_w_s1_wready", s1_axi_wready, 0);
    chk("early_w_m_wvalid", m_axi_wvalid, 0);
    step();
    s0_axi_awvalid = 1'b1; s0_axi_awid = 7'h04; s0_axi_awlen = 8'd3;
    s0_axi_wvalid = 1'b1; s0_axi_wdata = 64'hb0; s0_axi_wlast = 1'b0;
    #1;
    chk("aw_valid", m_axi_awvalid, 1);
    chk("aw_id_s1", m_axi_awid, 8'h82);
    chk("aw_len", m_axi_awlen, 3);
    chk("aw_addr", m_axi_awaddr, 36'h1234);
    chk("ar_concurrent", m_axi_arvalid, 1);
    chk("ar_concurrent_id", m_axi_arid, 8'h11);
    chk("aw_phase_s1_wready", s1_axi_wready, 0);
    chk("aw_phase_m_wvalid", m_axi_wvalid, 0);
    chk("s0_awready_blocked", s0_axi_awready, 0);
    m_axi_awready = 1'b1;
    #1;
    chk("s1_awready", s1_axi_awready, 1);
    step();
    s1_axi_awvalid = 1'b0; s0_axi_arvalid = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 4; c++) begin
      s1_axi_wdata = 64'ha0 + 64'(nb);
      s1_axi_wlast = (nb == 3);
      m_axi_wready = (c != 1);
      #1;
      chk("w_wvalid", m_axi_wvalid, 1);
      chk("w_data", m_axi_wdata, 64'ha0 + 64'(nb));
      chk("w_s0_wready", s0_axi_wready, 0);
      chk("w_s1_wready", s1_axi_wready, m_axi_wready);
      chk("w_no_aw", m_axi_awvalid, 0);
      if (m_axi_wvalid && m_axi_wready) nb++;
      step();
    end
    chk("w_beats", 64'(nb), 4);
    s1_axi_wvalid = 1'b0; s1_axi_wlast = 1'b0; m_axi_wready = 1'b1;
    #1;
    chk("after_wlast_s0_wready", s0_axi_wready, 0);
    chk("after_wlast_awvalid", m_axi_awvalid, 0);
    step();
    chk("s0_aw_issue", m_axi_awvalid, 1);
    chk("s0_aw_id", m_axi_awid, 8'h04);
    step();

    // reset during beat 2 of s0's 4-beat burst
    #1;
    chk("s0_beat1_wvalid", m_axi_wvalid, 1);
    chk("s0_beat1_data", m_axi_wdata, 64'hb0);
    step();
    s0_axi_wdata = 64'hb1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort_wvalid", m_axi_wvalid, 0);
    chk("abort_s0_wready", s0_axi_wready, 0);
    chk("abort_awvalid", m_axi_awvalid, 0);
    s1_axi_awvalid = 1'b1; s1_axi_awid = 7'h02;
    step();
    chk("post_rst_tie_awid", m_axi_awid, 8'h04);
    chk("post_rst_tie_awvalid", m_axi_awvalid, 1);
    s0_axi_awvalid = 1'b0; s1_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0;

    // R/B routing table
    for (int i = 0; i < 5; i++) begin
      m_axi_rid = tbl[i].rid; m_axi_rvalid = tbl[i].rv; m_axi_rlast = tbl[i].rl;
      s0_axi_rready = tbl[i].s0rr; s1_axi_rready = tbl[i].s1rr;
      m_axi_bid = tbl[i].bid; m_axi_bvalid = tbl[i].bv;
      s0_axi_bready = tbl[i].s0br; s1_axi_bready = tbl[i].s1br;
      #1;
      rid_seen = tbl[i].rid[IW] ? s1_axi_rid : s0_axi_rid;
      rl_seen  = tbl[i].rid[IW] ? s1_axi_rlast : s0_axi_rlast;
      chk($sformatf("v%0d_s0_rvalid", i), s0_axi_rvalid, tbl[i].e_s0rv);
      chk($sformatf("v%0d_s1_rvalid", i), s1_axi_rvalid, tbl[i].e_s1rv);
      chk($sformatf("v%0d_rid", i), rid_seen, tbl[i].e_rid);
      chk($sformatf("v%0d_rlast", i), rl_seen, tbl[i].e_rl);
      chk($sformatf("v%0d_m_rready", i), m_axi_rready, tbl[i].e_mrr);
      chk($sformatf("v%0d_s0_bvalid", i), s0_axi_bvalid, tbl[i].e_s0bv);
      chk($sformatf("v%0d_s1_bvalid", i), s1_axi_bvalid, tbl[i].e_s1bv);
      chk($sformatf("v%0d_m_bready", i), m_axi_bready, tbl[i].e_mbr);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
